// File: rtl/pipelined_select_extreme_if.sv
// rtl/pipelined_select_extreme_if.sv - handshake and data bundle for the pipelined extreme-value selector
interface pipelined_select_extreme_if #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16
);
  localparam int INDEX_WIDTH = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in;
  logic [NUM_WAY-1:0]                          condition_in;
  logic                                        mode_in;
  logic                                        valid_in;
  logic                                        ready_out;
  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         select_out;
  logic [INDEX_WIDTH-1:0]                      index_out;
  logic                                        found_out;
  logic                                        valid_out;
  logic                                        ready_in;

  // Upstream/downstream side that feeds transactions and consumes results
  modport master (
    output way_flatted_in, condition_in, mode_in, valid_in, ready_in,
    input  ready_out, select_out, index_out, found_out, valid_out
  );

  // Selector side
  modport slave (
    input  way_flatted_in, condition_in, mode_in, valid_in, ready_in,
    output ready_out, select_out, index_out, found_out, valid_out
  );
endinterface

// File: rtl/pipelined_select_extreme.sv
// rtl/pipelined_select_extreme.sv - registered comparison tree returning the biggest or smallest qualifying way
module pipelined_select_extreme #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16
) (
  input logic                     clk_in,
  input logic                     reset_in,
  pipelined_select_extreme_if.slave bus
);
  localparam int W           = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int NUM_STAGE   = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int INDEX_WIDTH = NUM_STAGE;
  localparam int NUM_PAD     = 1 << NUM_STAGE;

  typedef struct packed {
    logic                   en;
    logic [W-1:0]           val;
    logic [INDEX_WIDTH-1:0] idx;
  } node_t;

  // Pick one of two children; a is always the lower-index side so ties keep a.
  function automatic node_t f_merge(input node_t a, input node_t b, input logic mode);
    node_t r;
    if (a.en && b.en) begin
      if (mode ? (b.val < a.val) : (b.val > a.val)) r = b;
      else                                          r = a;
    end else if (a.en) begin
      r = a;
    end else if (b.en) begin
      r = b;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  // Heap layout: node k has children 2k and 2k+1, root is 1, leaves live at
  // NUM_PAD..2*NUM_PAD-1 and are the (padded) input ways themselves.
  node_t                r_node [1:NUM_PAD-1];
  node_t                w_tree [1:2*NUM_PAD-1];
  node_t                w_next [1:NUM_PAD-1];
  logic [NUM_STAGE-1:0] r_vld;
  logic [NUM_STAGE-1:0] w_stage_mode;
  logic                 w_en;

  assign w_en          = bus.ready_in || !bus.valid_out;
  assign bus.ready_out = w_en;
  assign bus.valid_out = r_vld[NUM_STAGE-1];
  assign bus.found_out = r_node[1].en;
  assign bus.select_out = r_node[1].val;
  assign bus.index_out = r_node[1].idx;

  for (genvar i = 0; i < NUM_PAD; i++) begin : g_leaf
    if (i < NUM_WAY) begin : g_real
      assign w_tree[NUM_PAD+i] = '{en:  bus.condition_in[i],
                                   val: bus.way_flatted_in[i*W +: W],
                                   idx: INDEX_WIDTH'(i)};
    end else begin : g_pad
      assign w_tree[NUM_PAD+i] = '0;
    end
  end

  // Stage s holds the nodes at tree depth NUM_STAGE-1-s; it merges using the
  // mode of the transaction it is about to capture.
  for (genvar k = 1; k < NUM_PAD; k++) begin : g_node
    localparam int STG = NUM_STAGE - $clog2(k + 1);
    assign w_tree[k] = r_node[k];
    assign w_next[k] = f_merge(w_tree[2*k], w_tree[2*k+1], w_stage_mode[STG]);
  end

  if (NUM_STAGE > 1) begin : g_mode
    logic [NUM_STAGE-2:0] r_mode;

    // Carry each transaction's mode alongside its partial results
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        r_mode <= '0;
      end else if (w_en) begin
        r_mode[0] <= bus.mode_in;
        for (int s = 1; s < NUM_STAGE - 1; s++) begin
          r_mode[s] <= r_mode[s-1];
        end
      end
    end

    assign w_stage_mode = {r_mode, bus.mode_in};
  end else begin : g_nomode
    assign w_stage_mode = bus.mode_in;
  end

  // Advance every stage together; reset clears data too so outputs read zero
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_vld <= '0;
      for (int k = 1; k < NUM_PAD; k++) begin
        r_node[k] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= bus.valid_in;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      for (int k = 1; k < NUM_PAD; k++) begin
        r_node[k] <= w_next[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_select_extreme.sv
// tb/tb_pipelined_select_extreme.sv - directed self-checking bench for the pipelined extreme-value selector
module tb_pipelined_select_extreme;
  logic clk = 1'b0;
  logic reset_in;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  localparam logic [63:0] V1 = 64'hABCD_5234_5234_ABA5;
  localparam logic [15:0] C1 = 16'b1110_0111_1110_0111;
  localparam logic [63:0] V2 = 64'h587C_2934_2934_587A;
  localparam logic [15:0] C2 = 16'b1011_0111_1111_1111;
  localparam logic [63:0] V7 = 64'h7777_7777_7777_7777;
  localparam logic [63:0] VR = 64'h0123_4567_89AB_CDEF;

  typedef struct packed {
    logic [63:0] ways;
    logic [15:0] cond;
    logic        mode;
    logic [3:0]  sel;
    logic [3:0]  idx;
    logic        found;
  } vec_t;

  pipelined_select_extreme_if #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(16)) intf16 ();
  pipelined_select_extreme_if #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(5))  intf5 ();
  pipelined_select_extreme_if #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(1))  intf1 ();

  pipelined_select_extreme #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(16)) u_dut16 (
    .clk_in(clk), .reset_in(reset_in), .bus(intf16));
  pipelined_select_extreme #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(5)) u_dut5 (
    .clk_in(clk), .reset_in(reset_in), .bus(intf5));
  pipelined_select_extreme #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(1)) u_dut1 (
    .clk_in(clk), .reset_in(reset_in), .bus(intf1));

  task automatic run16(input logic [63:0] ways, input logic [15:0] cond, input logic mode,
                       output int lat, output logic [3:0] sel, output logic [3:0] idx,
                       output logic found, output logic vout);
    intf16.way_flatted_in = ways;
    intf16.condition_in   = cond;
    intf16.mode_in        = mode;
    intf16.valid_in       = 1'b1;
    @(posedge clk); #1;
    intf16.valid_in = 1'b0;
    lat = 1;
    while (!intf16.valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sel = intf16.select_out; idx = intf16.index_out; found = intf16.found_out; vout = intf16.valid_out;
    @(posedge clk); #1;
  endtask

  task automatic run5(input logic [19:0] ways, input logic [4:0] cond, input logic mode,
                      output int lat, output logic [3:0] sel, output logic [3:0] idx,
                      output logic found, output logic vout);
    intf5.way_flatted_in = ways;
    intf5.condition_in   = cond;
    intf5.mode_in        = mode;
    intf5.valid_in       = 1'b1;
    @(posedge clk); #1;
    intf5.valid_in = 1'b0;
    lat = 1;
    while (!intf5.valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sel = intf5.select_out; idx = {1'b0, intf5.index_out}; found = intf5.found_out; vout = intf5.valid_out;
    @(posedge clk); #1;
  endtask

  task automatic run1(input logic [3:0] ways, input logic cond, input logic mode,
                      output int lat, output logic [3:0] sel, output logic [3:0] idx,
                      output logic found, output logic vout);
    intf1.way_flatted_in = ways;
    intf1.condition_in   = cond;
    intf1.mode_in        = mode;
    intf1.valid_in       = 1'b1;
    @(posedge clk); #1;
    intf1.valid_in = 1'b0;
    lat = 1;
    while (!intf1.valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sel = intf1.select_out; idx = {3'b000, intf1.index_out}; found = intf1.found_out; vout = intf1.valid_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_total++; if ({intf16.valid_out, intf16.found_out, intf16.select_out, intf16.index_out} !== 10'h0) $display("FAIL reset16_outputs: got %h expected 0", {intf16.valid_out, intf16.found_out, intf16.select_out, intf16.index_out}); else n_pass++;
    n_total++; if (intf16.ready_out !== 1'b1) $display("FAIL reset16_ready: got %b expected 1", intf16.ready_out); else n_pass++;
    n_total++; if ({intf5.valid_out, intf5.found_out, intf5.select_out, intf5.index_out} !== 9'h0) $display("FAIL reset5_outputs: got %h expected 0", {intf5.valid_out, intf5.found_out, intf5.select_out, intf5.index_out}); else n_pass++;
    n_total++; if (intf5.ready_out !== 1'b1) $display("FAIL reset5_ready: got %b expected 1", intf5.ready_out); else n_pass++;
    n_total++; if ({intf1.valid_out, intf1.found_out, intf1.select_out, intf1.index_out} !== 7'h0) $display("FAIL reset1_outputs: got %h expected 0", {intf1.valid_out, intf1.found_out, intf1.select_out, intf1.index_out}); else n_pass++;
    n_total++; if (intf1.ready_out !== 1'b1) $display("FAIL reset1_ready: got %b expected 1", intf1.ready_out); else n_pass++;
  endtask

  task automatic test_max_mode;
    int lat; logic [3:0] sel, idx; logic found, vout;
    run16(V1, C1, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (lat != 4) $display("FAIL max1_latency: got %0d expected 4", lat); else n_pass++;
    n_total++; if (sel !== 4'hc) $display("FAIL max1_select: got %h expected c", sel); else n_pass++;
    n_total++; if (idx !== 4'd13) $display("FAIL max1_index: got %0d expected 13", idx); else n_pass++;
    n_total++; if (found !== 1'b1) $display("FAIL max1_found: got %b expected 1", found); else n_pass++;
    run16(V2, C2, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (sel !== 4'hc) $display("FAIL max2_select: got %h expected c", sel); else n_pass++;
    n_total++; if (idx !== 4'd12) $display("FAIL max2_index: got %0d expected 12", idx); else n_pass++;
    n_total++; if (found !== 1'b1) $display("FAIL max2_found: got %b expected 1", found); else n_pass++;
  endtask

  task automatic test_min_tie;
    int lat; logic [3:0] sel, idx; logic found, vout;
    run16(V1, C1, 1'b1, lat, sel, idx, found, vout);
    n_total++; if (sel !== 4'h2) $display("FAIL min_select: got %h expected 2", sel); else n_pass++;
    n_total++; if (idx !== 4'd6) $display("FAIL min_index: got %0d expected 6", idx); else n_pass++;
    run16(V7, 16'hFFFF, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (sel !== 4'h7) $display("FAIL tie_select: got %h expected 7", sel); else n_pass++;
    n_total++; if (idx !== 4'd0) $display("FAIL tie_index: got %0d expected 0", idx); else n_pass++;
  endtask

  task automatic test_empty;
    int lat; logic [3:0] sel, idx; logic found, vout;
    run16(V1, 16'h0000, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (vout !== 1'b1) $display("FAIL empty_valid: got %b expected 1", vout); else n_pass++;
    n_total++; if (found !== 1'b0) $display("FAIL empty_found: got %b expected 0", found); else n_pass++;
    n_total++; if (sel !== 4'h0) $display("FAIL empty_select: got %h expected 0", sel); else n_pass++;
    n_total++; if (idx !== 4'd0) $display("FAIL empty_index: got %0d expected 0", idx); else n_pass++;
  endtask

  task automatic test_stream;
    vec_t v [8];
    int   sent, got, cyc, extra, stalls;
    logic in_x, out_x, prev_stall;
    logic [3:0] h_sel, h_idx;
    logic h_found;
    v[0] = '{V1, C1, 1'b0, 4'hc, 4'd13, 1'b1};
    v[1] = '{V1, C1, 1'b1, 4'h2, 4'd6, 1'b1};
    v[2] = '{V2, C2, 1'b0, 4'hc, 4'd12, 1'b1};
    v[3] = '{V2, C2, 1'b1, 4'h2, 4'd7, 1'b1};
    v[4] = '{V7, 16'hFFFF, 1'b0, 4'h7, 4'd0, 1'b1};
    v[5] = '{V7, 16'hFFFF, 1'b1, 4'h7, 4'd0, 1'b1};
    v[6] = '{V1, 16'h0000, 1'b0, 4'h0, 4'd0, 1'b0};
    v[7] = '{VR, 16'hFFFF, 1'b1, 4'h0, 4'd15, 1'b1};
    sent = 0; got = 0; cyc = 0; stalls = 0; prev_stall = 1'b0;
    h_sel = '0; h_idx = '0; h_found = 1'b0;
    while (got < 8 && cyc < 60) begin
      intf16.valid_in = (sent < 8);
      if (sent < 8) begin
        intf16.way_flatted_in = v[sent].ways;
        intf16.condition_in   = v[sent].cond;
        intf16.mode_in        = v[sent].mode;
      end
      intf16.ready_in = !(cyc >= 5 && cyc <= 7);
      #1;
      if (prev_stall) begin
        n_total++; if ({intf16.valid_out, intf16.select_out, intf16.index_out, intf16.found_out} !== {1'b1, h_sel, h_idx, h_found}) $display("FAIL stream_hold cyc%0d: got %h expected %h", cyc, {intf16.valid_out, intf16.select_out, intf16.index_out, intf16.found_out}, {1'b1, h_sel, h_idx, h_found}); else n_pass++;
      end
      prev_stall = intf16.valid_out && !intf16.ready_in;
      if (prev_stall) begin
        stalls++;
        n_total++; if (intf16.ready_out !== 1'b0) $display("FAIL stream_ready_stall cyc%0d: got %b expected 0", cyc, intf16.ready_out); else n_pass++;
        h_sel = intf16.select_out; h_idx = intf16.index_out; h_found = intf16.found_out;
      end
      in_x  = intf16.valid_in && intf16.ready_out;
      out_x = intf16.valid_out && intf16.ready_in;
      if (out_x) begin
        n_total++; if ({intf16.select_out, intf16.index_out, intf16.found_out} !== {v[got].sel, v[got].idx, v[got].found}) $display("FAIL stream_out[%0d]: got %h expected %h", got, {intf16.select_out, intf16.index_out, intf16.found_out}, {v[got].sel, v[got].idx, v[got].found}); else n_pass++;
        got++;
      end
      @(posedge clk); #1;
      if (in_x) sent++;
      cyc++;
    end
    intf16.valid_in = 1'b0;
    intf16.ready_in = 1'b1;
    n_total++; if (got != 8) $display("FAIL stream_count: got %0d expected 8", got); else n_pass++;
    n_total++; if (stalls != 3) $display("FAIL stream_stall_cycles: got %0d expected 3", stalls); else n_pass++;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (intf16.valid_out) extra++;
      @(posedge clk); #1;
    end
    n_total++; if (extra != 0) $display("FAIL stream_extra: got %0d expected 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, stale; logic [3:0] sel, idx; logic found, vout;
    intf16.valid_in = 1'b1;
    intf16.way_flatted_in = V1; intf16.condition_in = C1; intf16.mode_in = 1'b0;
    @(posedge clk); #1;
    intf16.mode_in = 1'b1;
    @(posedge clk); #1;
    intf16.way_flatted_in = V2; intf16.condition_in = C2; intf16.mode_in = 1'b0;
    @(posedge clk); #1;
    intf16.mode_in = 1'b1;
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    intf16.valid_in = 1'b0;
    n_total++; if ({intf16.valid_out, intf16.found_out, intf16.select_out, intf16.index_out} !== 10'h0) $display("FAIL rstmid_outputs: got %h expected 0", {intf16.valid_out, intf16.found_out, intf16.select_out, intf16.index_out}); else n_pass++;
    n_total++; if (intf16.ready_out !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", intf16.ready_out); else n_pass++;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (intf16.valid_out) stale++;
    end
    n_total++; if (stale != 0) $display("FAIL rstmid_stale: got %0d expected 0", stale); else n_pass++;
    run16(V2, C2, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (lat != 4) $display("FAIL rstmid_latency: got %0d expected 4", lat); else n_pass++;
    n_total++; if ({sel, idx, found} !== {4'hc, 4'd12, 1'b1}) $display("FAIL rstmid_result: got %h expected %h", {sel, idx, found}, {4'hc, 4'd12, 1'b1}); else n_pass++;
  endtask

  task automatic test_n5;
    int lat; logic [3:0] sel, idx; logic found, vout;
    run5(20'h39916, 5'b11111, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (lat != 3) $display("FAIL n5_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if ({sel, idx, found} !== {4'h9, 4'd2, 1'b1}) $display("FAIL n5_max_tie: got %h expected %h", {sel, idx, found}, {4'h9, 4'd2, 1'b1}); else n_pass++;
    run5(20'h39916, 5'b11111, 1'b1, lat, sel, idx, found, vout);
    n_total++; if ({sel, idx, found} !== {4'h1, 4'd1, 1'b1}) $display("FAIL n5_min: got %h expected %h", {sel, idx, found}, {4'h1, 4'd1, 1'b1}); else n_pass++;
    run5(20'h39916, 5'b10000, 1'b1, lat, sel, idx, found, vout);
    n_total++; if ({sel, idx, found} !== {4'h3, 4'd4, 1'b1}) $display("FAIL n5_top_way: got %h expected %h", {sel, idx, found}, {4'h3, 4'd4, 1'b1}); else n_pass++;
    run5(20'h39916, 5'b00000, 1'b0, lat, sel, idx, found, vout);
    n_total++; if ({vout, sel, idx, found} !== {1'b1, 4'h0, 4'd0, 1'b0}) $display("FAIL n5_empty: got %h expected %h", {vout, sel, idx, found}, {1'b1, 4'h0, 4'd0, 1'b0}); else n_pass++;
  endtask

  task automatic test_n1;
    int lat; logic [3:0] sel, idx; logic found, vout;
    run1(4'hb, 1'b1, 1'b0, lat, sel, idx, found, vout);
    n_total++; if (lat != 1) $display("FAIL n1_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if ({sel, idx, found} !== {4'hb, 4'd0, 1'b1}) $display("FAIL n1_hit: got %h expected %h", {sel, idx, found}, {4'hb, 4'd0, 1'b1}); else n_pass++;
    run1(4'hb, 1'b0, 1'b1, lat, sel, idx, found, vout);
    n_total++; if ({vout, sel, idx, found} !== {1'b1, 4'h0, 4'd0, 1'b0}) $display("FAIL n1_empty: got %h expected %h", {vout, sel, idx, found}, {1'b1, 4'h0, 4'd0, 1'b0}); else n_pass++;
  endtask

  initial begin
    reset_in = 1'b1;
    intf16.way_flatted_in = '0; intf16.condition_in = '0; intf16.mode_in = 1'b0; intf16.valid_in = 1'b0; intf16.ready_in = 1'b1;
    intf5.way_flatted_in  = '0; intf5.condition_in  = '0; intf5.mode_in  = 1'b0; intf5.valid_in  = 1'b0; intf5.ready_in  = 1'b1;
    intf1.way_flatted_in  = '0; intf1.condition_in  = '0; intf1.mode_in  = 1'b0; intf1.valid_in  = 1'b0; intf1.ready_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_in = 1'b0;
    test_reset();
    test_max_mode();
    test_min_tie();
    test_empty();
    test_stream();
    test_reset_mid();
    test_n5();
    test_n1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipelined_select_extreme.md
# pipelined_select_extreme

Pipelined, handshaked successor to the combinational biggest-value selector. Each accepted transaction carries NUM_WAY flattened ways and a per-way condition mask. The block returns the largest or the smallest qualifying way, its index, and a found flag. The reduction is a registered comparison tree that accepts one transaction per cycle and stalls under downstream backpressure. It serves replacement, arbitration and priority logic where the combinational tree no longer meets timing.

## Interface
- SINGLE_WAY_WIDTH_IN_BITS, 4, unsigned width of one way
- NUM_WAY, 16, number of ways; any value ≥ 1
- NUM_STAGE, derived as max(1, clog2(NUM_WAY)); pipeline depth, not user-set
- INDEX_WIDTH, derived as max(1, clog2(NUM_WAY))

Ports:
- clk_in  input  1  clock; all logic on the rising edge
- reset_in  input  1  reset, synchronous and active-high
- way_flatted_in  input  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  packed ways; way i is bits [i*W +: W]
- condition_in  input  NUM_WAY  bit i = 1 makes way i a candidate
- mode_in  input  1  0 selects biggest, 1 selects smallest
- valid_in  input  1  input transaction present
- ready_out  output  1  block can accept a transaction this cycle
- select_out  output  SINGLE_WAY_WIDTH_IN_BITS  winning value
- index_out  output  INDEX_WIDTH  winning way index
- found_out  output  1  at least one condition bit was set
- valid_out  output  1  output transaction present
- ready_in  input  1  downstream accepts the output

## Operation
- Transfer rules:
  - Input transfer happens when valid_in && ready_out.
  - Output transfer happens when valid_out && ready_in.
- Stage 0 registers the leaf pairs.
  - Ways are padded to the next power of two with disabled entries.
  - Each node holds {enable, value, index}.
- Node merge, for children a (lower index) and b:
  - If only one child is enabled, take it.
  - If neither is enabled, the result is disabled with value 0 and index 0.
  - If both are enabled in mode 0, take b only if b.value > a.value; otherwise take a.
  - If both are enabled in mode 1, take b only if b.value < a.value; otherwise take a.
  - Ties always go to the lower index.
- Comparisons are unsigned, at full width, with no wrap.
- mode_in travels with its transaction through every stage. Back-to-back transactions may use different modes.
- NUM_WAY = 1: a single register stage. The output is way 0 when condition bit 0 is set, else it is disabled.
- Final stage outputs:
  - found_out is the root enable.
  - select_out and index_out are the root value and index; both are 0 when found_out = 0.
- Per-stage valid bits shift with the data.
- Global enable en = ready_in || !valid_out.
  - All stages advance only when en = 1.
  - ready_out = en, which is combinational from ready_in and valid_out.
  - Internal bubbles are not squeezed while stalled.
- Data in a stage whose valid bit is 0 is don't-care at the outputs, except that outputs are zeroed after reset.

## Timing
- Latency: a transaction accepted on edge t appears with valid_out = 1 after edge t+NUM_STAGE-1. It is visible NUM_STAGE cycles after acceptance, with no stalls.
- Throughput: one transaction per cycle when ready_in is held at 1.
- Stall: while valid_out && !ready_in:
  - select_out, index_out, found_out and valid_out hold exactly.
  - ready_out = 0.
  - No transaction is lost or duplicated.
- Reset: on any edge with reset_in = 1:
  - All stage valid bits clear, so valid_out = 0.
  - select_out = 0, index_out = 0, found_out = 0.
  - ready_out = 1 in the first cycle after reset.
  - In-flight transactions are discarded. Reset overrides a simultaneous input transfer.
- Simultaneous input and output transfer in the same cycle is legal. The pipeline shifts by one.
- valid_in = 0 with en = 1 inserts a bubble.

## Test plan
- Max mode, W=4, N=16.
  - Stimulus: ways (15→0) {a,b,c,d,5,2,3,4,5,2,3,4,a,b,a,5}, condition 16'b1110_0111_1110_0111.
  - Required: select_out = 4'hc, index_out = 13, found_out = 1, after exactly 4 cycles.
- Max mode, second vector.
  - Stimulus: ways {5,8,7,c,2,9,3,4,2,9,3,4,5,8,7,a}, condition 16'b1011_0111_1111_1111.
  - Required: select_out = 4'hc, index_out = 12.
- Min mode with tie.
  - Stimulus: the first vector with mode_in = 1.
  - Required: select_out = 4'h2, index_out = 6; ways 10 and 6 tie and the lower index wins.
  - Follow-up: all ways 4'h7, all enabled, mode 0 gives index_out = 0.
- Empty mask.
  - Stimulus: condition = 0.
  - Required: found_out = 0, select_out = 0, index_out = 0, valid_out = 1.
- Streaming with backpressure.
  - Stimulus: issue 8 back-to-back transactions with alternating mode; hold ready_in = 0 for 3 cycles mid-stream.
  - Required: outputs arrive in order with correct values, held stable while stalled; ready_out = 0 during the stall; exactly 8 output transfers.
- Reset mid-operation.
  - Stimulus: assert reset_in for 1 cycle with 3 transactions in flight.
  - Required: next cycle valid_out = 0 with all outputs 0; no stale transaction ever emerges; a new transaction afterwards returns correctly after 4 cycles.
  - Also cover N=5 (padding, index_out width 3) and N=1.
